alu_seq: RTL

Parametrised, registered ALU with a valid/ready handshake on both sides and four result flags (C, Z, V, N). It adds a carry register so ADC/SBB can chain multi-word arithmetic, an iterative multi-cycle multiplier, and an arithmetic shift. It sits between an operand source (sequencer/register file) and a result sink, and accepts one operation per handshake.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_seq_mul.sv | 66 ++++++
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by alu_seq and its multiplier.
//   - opcode constants OP_ADD..OP_SRA (13-15 are illegal)
//   - flag bit positions inside the packed flag register
//   - FSM state encoding
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts a run)
//   start         load a/b and begin (ignored while a run is active)
//   a, b          multiplicand, multiplier
//   done          one-cycle pulse: product is complete
//   product       full 2*WIDTH-bit product (valid while done is high)
// Bit 0 of the multiplier is consumed on the start edge itself, so the last
// of the WIDTH partial products is added WIDTH-1 edges later and done is seen
// by the parent on the edge WIDTH cycles after start.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !busy_reg) begin
        acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier_reg <= b >> 1;
        cnt_reg    <= CW'(WIDTH-1);
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides, C/Z/V/N flags,
// a carry register for ADC/SBB chaining, an iterative MUL and shifts.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, op)
//   out_valid/out_ready   result handshake (result, flags, err)
//   result                registered result
//   carry/zero/overflow/negative  registered flags
//   err                   result came from an illegal opcode
// The carry output register doubles as the chaining carry (Creg).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg, flags_next;
  logic             err_reg;

  logic             accept;
  logic             load;
  logic             mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // single-cycle datapath
  logic [SHW-1:0]   sh;
  logic             cin;
  logic [WIDTH:0]   sum_ext, diff_ext, shl_ext, shr_ext, sra_ext;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  // values loaded into the output registers
  logic [WIDTH-1:0] ld_res;
  logic             ld_c, ld_v, ld_err;

  assign in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == ST_HOLD);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    sh  = b[SHW-1:0];
    cin = ((op == OP_ADC) || (op == OP_SBB)) ? flags_reg[FLG_C] : 1'b0;
    sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    // An extra guard bit on the shifted-out side captures the last bit lost;
    // it stays 0 for a zero shift amount.
    shl_ext  = {1'b0, a} << sh;
    shr_ext  = {a, 1'b0} >> sh;
    sra_ext  = $signed({a, 1'b0}) >>> sh;
    add_v = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ext[WIDTH-1]  != a[WIDTH-1]);
    sub_v = (a[WIDTH-1] != b[WIDTH-1]) & (diff_ext[WIDTH-1] != a[WIDTH-1]);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_SBB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = sub_v;
      end
      OP_CMP: begin
        alu_res = a;
        alu_c   = diff_ext[WIDTH];
        alu_v   = sub_v;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_SRA: begin
        alu_res = sra_ext[WIDTH:1];
        alu_c   = sra_ext[0];
      end
      OP_MUL: ;  // handled by the multiplier path
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    mul_start  = 1'b0;
    ld_res     = alu_res;
    ld_c       = alu_c;
    ld_v       = alu_v;
    ld_err     = alu_err;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_BUSY;
          end else begin
            load       = 1'b1;
            state_next = ST_HOLD;
          end
        end else if ((state_reg == ST_HOLD) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          load       = 1'b1;
          ld_res     = mul_product[WIDTH-1:0];
          ld_c       = |mul_product[2*WIDTH-1:WIDTH];
          ld_v       = |mul_product[2*WIDTH-1:WIDTH];
          ld_err     = 1'b0;
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    flags_next        = '0;
    flags_next[FLG_C] = ld_c;
    flags_next[FLG_Z] = (ld_res == '0);
    flags_next[FLG_V] = ld_v;
    flags_next[FLG_N] = ld_res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        result_reg <= ld_res;
        flags_reg  <= flags_next;
        err_reg    <= ld_err;
      end
    end
  end

  assign result   = result_reg;
  assign carry    = flags_reg[FLG_C];
  assign zero     = flags_reg[FLG_Z];
  assign overflow = flags_reg[FLG_V];
  assign negative = flags_reg[FLG_N];
  assign err      = err_reg;

endmodule
